mux_sel_sequencer: RTL
======================

# mux_sel_sequencer

Select generator that drives the 2-bit `s` input of the `mux41` 4:1 multiplexer, sitting directly upstream of it. It scans the enabled channels in round-robin order and holds each selection for a programmable number of clock cycles. It skips channels that are masked off and flags every selection change and every completed scan. It is used for time-multiplexed outputs such as digit scanning in the clock display.

## Interface
Parameters:
- `DWELL_CYCLES`, default 4: clock cycles each selection is held; legal range ≥1.
- `BLANK_CYCLES`, default 1: blank gap between selections; legal range ≥1; used only with `MUX_SEL_BLANK_EN`.

Ports:
- `clk`  in  1  single system clock; rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  when 1, dwell/blank counting runs; when 0, all counting freezes.
- `ch_mask`  in  4  channel enables; bit i enables channel i.
- `s`  out  2  mux select; connects to `mux41.s`.
- `sel_valid`  out  1  1 when `s` addresses an enabled channel and is not blanked.
- `sel_chg`  out  1  one-cycle pulse in the first cycle `s` carries a new value.
- `wrap`  out  1  one-cycle pulse in the first cycle of a new scan.

## Operation
- All outputs are registered.
- Reset values: `s`=0, `sel_valid`=0, `sel_chg`=0, `wrap`=0. State is IDLE and the counter is 0.
- States: IDLE, DWELL, BLANK. BLANK exists only when the macro is defined.
- IDLE:
  - `sel_valid`=0 and `s` keeps its last value.
  - When `en`=1 and `ch_mask`≠0, load `s` with the lowest set bit index, set `sel_valid`=1, pulse `sel_chg`=1 and go to DWELL.
  - `wrap` does not pulse on this entry.
- DWELL:
  - The counter increments on every cycle with `en`=1.
  - The advance condition is counter = `DWELL_CYCLES`−1 with `en`=1.
  - Next channel: search `s`+1, `s`+2, `s`+3, `s` (mod 4) and take the first index whose mask bit is set.
  - If the next channel equals the current one, `s` is unchanged, `sel_chg` stays 0 and the counter restarts.
  - `wrap` pulses when next index ≤ current index. This includes the single-channel case.
  - If `ch_mask`[`s`] clears mid-dwell, advance on the next edge regardless of `en` or the counter value. The counter resets.
  - If `ch_mask`=0, go to IDLE on the next edge and set `sel_valid`=0.
- BLANK (macro only):
  - On advance, `s` holds the old value and `sel_valid`=0 for `BLANK_CYCLES` counted cycles.
  - Then `s` takes the next value with `sel_valid`=1 and `sel_chg`=1. `wrap` is issued alongside that `sel_chg`.
  - The next channel is re-evaluated at the end of BLANK against the current `ch_mask`.
  - If `ch_mask`=0 at the end of BLANK, go to IDLE.
- Counter width: $clog2 of max(`DWELL_CYCLES`, `BLANK_CYCLES`), minimum 1 bit.
- Counting wraps only through an advance; the counter never overflows.

## Timing
- From the first edge with `rst`=0, `en`=1 and `ch_mask`≠0, `sel_valid`/`s`/`sel_chg` update on that same edge. The registered outputs are visible in the following cycle.
- With `en` held at 1 and no macro, each selection is held exactly `DWELL_CYCLES` cycles. Channel period = `DWELL_CYCLES` × (number of enabled channels).
- With the macro, each slot is `DWELL_CYCLES` + `BLANK_CYCLES` cycles, and `sel_valid` is low for `BLANK_CYCLES` of them.
- `en`=0 stretches DWELL/BLANK cycle-for-cycle and never causes an advance.
- `rst` asserted mid-operation restores reset values on the next edge, whatever the state.
- Simultaneous events:
  - `ch_mask`=0 has priority over an advance.
  - Loss of the current channel has priority over counter expiry. Only one advance occurs.

## Configuration
- `MUX_SEL_BLANK_EN` defined: the BLANK state and `BLANK_CYCLES` are compiled in. A blank gap precedes every selection change; a self-advance with one channel has no blank.
- `MUX_SEL_BLANK_EN` undefined: no BLANK state, `BLANK_CYCLES` is ignored, and advances go directly DWELL→DWELL.

## Test plan
- Reset, then `en`=1, `ch_mask`=4'hF, `DWELL_CYCLES`=4, no macro → `s` goes 0,1,2,3,0. Each value lasts 4 cycles, `sel_chg` pulses 5 times, and `wrap` pulses once, at the return to 0.
- `ch_mask`=4'b1010 → `s` alternates 1,3,1. Channels 0 and 2 never appear, and `wrap` pulses on each 3→1.
- Clear `ch_mask`[`s`] while at `s`=2 in mid-dwell with mask 4'hF → `s`=3 on the next edge, with a new full 4-cycle dwell.
- Hold `en`=0 for 5 cycles mid-dwell → `s` is frozen and `sel_chg` stays 0. On resuming, the remaining dwell completes for a total of 9 cycles with `s` unchanged.
- `ch_mask`=0 during DWELL, then 4'b0100 → `sel_valid`=0 for the IDLE interval, then `s`=2 with `sel_valid`=1 and `sel_chg`=1. The single channel re-dwells with a `wrap` pulse every 4 cycles.
- With the macro, `BLANK_CYCLES`=2 and mask 4'hF → the pattern is 4 cycles valid, then 2 cycles with `sel_valid`=0 and `s` held, then the new `s`. Assert `rst` during BLANK → `s`=0 and `sel_valid`=0 on the next edge.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// Round-robin select generator for the mux41 's' input. It holds each enabled channel for DWELL_CYCLES and skips masked channels.
// Latency: all outputs are registered and update on the edge that sees the triggering inputs.
// Backpressure: en=0 freezes dwell/blank counting. Optional macro MUX_SEL_BLANK_EN inserts a BLANK_CYCLES gap before each change.
module mux_sel_sequencer #(
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] ch_mask,
  output logic [1:0] s,
  output logic       sel_valid,
  output logic       sel_chg,
  output logic       wrap
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
`ifdef MUX_SEL_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_BLANK} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_DWELL} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    s_q, s_d;
  logic          sel_valid_q, sel_valid_d;
  logic          sel_chg_q, sel_chg_d;
  logic          wrap_q, wrap_d;

  logic [1:0]    nxt;
  logic [1:0]    first;
  logic          cur_lost;
  logic          expire;

  // Search cur+1, cur+2, cur+3, cur (mod 4) and return the first enabled index.
  function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] mask);
    logic [1:0] res;
    logic [1:0] idx;
    res = cur;
    for (int k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

  // Lowest set bit index; zero when the mask is empty.
  function automatic logic [1:0] lowest_ch(input logic [3:0] mask);
    logic [1:0] res;
    res = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) res = 2'(k);
    end
    return res;
  endfunction

  assign nxt      = next_ch(s_q, ch_mask);
  assign first    = lowest_ch(ch_mask);
  assign cur_lost = ~ch_mask[s_q];
  assign expire   = en && (cnt_q == DWELL_LAST);

  // Next-state and next-output decode; pulses default low each cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    sel_valid_d = sel_valid_q;
    sel_chg_d   = 1'b0;
    wrap_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_valid_d = 1'b0;
        if (en && (ch_mask != 4'd0)) begin
          s_d         = first;
          sel_valid_d = 1'b1;
          sel_chg_d   = 1'b1;
          cnt_d       = '0;
          state_d     = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (ch_mask == 4'd0) begin
          // An empty mask wins over any pending advance.
          state_d     = ST_IDLE;
          sel_valid_d = 1'b0;
          cnt_d       = '0;
        end else if (cur_lost || expire) begin
          // A lost channel and an expiring count collapse into one advance.
          cnt_d = '0;
          if (nxt == s_q) begin
            // Single enabled channel: re-dwell in place, still a scan boundary.
            wrap_d = 1'b1;
          end else begin
`ifdef MUX_SEL_BLANK_EN
            state_d     = ST_BLANK;
            sel_valid_d = 1'b0;
`else
            s_d       = nxt;
            sel_chg_d = 1'b1;
            wrap_d    = (nxt <= s_q);
`endif
          end
        end else if (en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MUX_SEL_BLANK_EN
      ST_BLANK: begin
        if (en) begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d = '0;
            // The target is chosen here, against the mask as it is now.
            if (ch_mask == 4'd0) begin
              state_d = ST_IDLE;
            end else begin
              s_d         = nxt;
              sel_valid_d = 1'b1;
              sel_chg_d   = 1'b1;
              wrap_d      = (nxt <= s_q);
              state_d     = ST_DWELL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        sel_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s_q         <= 2'd0;
      sel_valid_q <= 1'b0;
      sel_chg_q   <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      sel_valid_q <= sel_valid_d;
      sel_chg_q   <= sel_chg_d;
      wrap_q      <= wrap_d;
    end
  end

  assign s         = s_q;
  assign sel_valid = sel_valid_q;
  assign sel_chg   = sel_chg_q;
  assign wrap      = wrap_q;

endmodule
